led_pwm_fader: RTL and testbench
================================

// Module: led_pwm_fader
// PURPOSE
//   Breathing-LED PWM stage fed by the free-running binary counter.
//   - Compares the counter value against an internal duty register to produce a PWM output.
//   - Ramps duty up, holds, ramps down, holds, and repeats via an FSM.
//   - Duty changes only at period boundaries, so the output is glitch-free.
//   - Sits between the counter output and the LED pins.
// PARAMETERS
//   WIDTH         8   counter/duty width; PWM period = 2^WIDTH counter steps
//   STEP          4   duty increment/decrement per period; 1..2^WIDTH-1
//   HOLD_PERIODS  16  periods spent in each hold state; >=1
//   HOLD_W        8   hold counter width; 2^HOLD_W >= HOLD_PERIODS
// PORTS
//   clk         in   1      system clock
//   rst         in   1      asynchronous reset, active-high
//   ena         in   1      counter advance strobe (same signal as the counter's enable)
//   cnt         in   WIDTH  counter value q
//   start       in   1      one-cycle pulse: begin breathing
//   stop        in   1      one-cycle pulse: fade out gracefully, then idle
//   pwm         out  1      registered PWM output
//   duty        out  WIDTH  current linear duty
//   busy        out  1      registered; 1 when state != IDLE
//   period_end  out  1      registered one-cycle pulse after each period boundary
// BEHAVIOUR
//   - Reset (asynchronous, usable mid-operation): pwm=0, duty=0, busy=0, period_end=0,
//     state=IDLE, hold count=0, pending stop cleared.
//   - Period boundary: pe = ena && cnt=={WIDTH{1'b1}}. All duty/FSM updates occur only
//     on clocks where pe=1. period_end <= pe (1-cycle latency).
//   - PWM: pwm <= (cnt < duty_eff) on every clock, regardless of ena (1-cycle latency).
//     duty_eff=0: pwm always 0.
//     duty_eff=MAX: pwm high for every cnt except MAX.
//   - FSM states: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
//     - IDLE: duty=0. start -> RAMP_UP on the next clock (no pe required); busy=1 one
//       cycle later.
//     - RAMP_UP @pe: duty <= min(duty+STEP, MAX), sum computed at WIDTH+1 bits and
//       saturated. When the new duty==MAX -> HOLD_HIGH, hold count cleared.
//     - HOLD_HIGH @pe: hold count++. At hold count==HOLD_PERIODS-1 -> RAMP_DOWN.
//     - RAMP_DOWN @pe: duty <= (duty>STEP) ? duty-STEP : 0. When the new duty==0 ->
//       IDLE if stop is pending (clear pending); else -> HOLD_LOW with hold count cleared.
//     - HOLD_LOW @pe: same counting as HOLD_HIGH, then -> RAMP_UP.
//   - stop in any non-IDLE state: sets pending stop. RAMP_UP, HOLD_HIGH and HOLD_LOW
//     switch to RAMP_DOWN immediately (next clock). From HOLD_LOW (duty=0) the next pe
//     takes the RAMP_DOWN duty==0 path -> IDLE.
//   - stop in IDLE: ignored.
//   - start while busy: ignored.
//   - start and stop in the same cycle: stop wins; from IDLE, stay IDLE.
//   - ena held low: no pe; duty, FSM state and hold count frozen; pwm still tracks cnt.
// CONFIGURATION
//   LED_FADER_GAMMA_EN
//     - Defined: duty_eff = (duty*duty) >> WIDTH, a 2*WIDTH-bit product, for
//       perceptual linearity (WIDTH=8: duty 128 -> 64, duty 255 -> 254).
//     - Undefined: duty_eff = duty.
//     - The duty output is always the linear value.
// TESTING (WIDTH=8, STEP=64, HOLD_PERIODS=2 unless stated; cnt driven as free-running
//   0..255 with ena=1)
//   1. rst=1 mid-ramp -> pwm=0, duty=0, busy=0, period_end=0 immediately;
//      after release, stays IDLE.
//   2. start pulse -> busy=1; duty 64,128,192,255 at successive pe; after 255,
//      state HOLD_HIGH.
//   3. Continue -> 2 periods at 255, then duty 191,127,63,0, then 2 periods at 0,
//      then 64 again (continuous).
//   4. duty=128 (gamma off) -> pwm high exactly for cnt 0..127, 1 cycle delayed;
//      128 highs per 256 cycles. Gamma on -> 64 highs.
//   5. stop during HOLD_HIGH -> RAMP_DOWN next clock; duty 191,127,63,0; then IDLE,
//      busy=0, pwm=0. start+stop same cycle in IDLE -> remains IDLE.
//   6. ena=0 for 100 cycles mid RAMP_UP -> duty, state and period_end unchanged;
//      resumes on the next pe after ena=1.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Breathing-LED PWM stage fed by an external free-running counter: ramp up, hold, ramp down, hold.
// Build macro LED_FADER_GAMMA_EN squares the duty before the compare; the duty output stays linear.
module led_pwm_fader #(
  parameter int WIDTH        = 8,
  parameter int STEP         = 4,
  parameter int HOLD_PERIODS = 16,
  parameter int HOLD_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cnt,
  input  logic             start,
  input  logic             stop,
  output logic             pwm,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             period_end
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HIGH = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LOW  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  DUTY_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]    STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  // Sum is formed one bit wider so an overflow past MAX clamps instead of wrapping.
  function automatic logic [WIDTH-1:0] duty_up(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    s = {1'b0, d} + STEP_X;
    duty_up = (s > {1'b0, DUTY_MAX}) ? DUTY_MAX : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] duty_down(input logic [WIDTH-1:0] d);
    duty_down = ({1'b0, d} > STEP_X) ? (d - STEP_X[WIDTH-1:0]) : '0;
  endfunction

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_stop_pend;
  logic [WIDTH-1:0]  r_duty;
  logic              r_pwm;
  logic              r_busy;
  logic              r_pe;

  logic              w_pe;
  logic [WIDTH-1:0]  w_up;
  logic [WIDTH-1:0]  w_down;
  logic [WIDTH-1:0]  w_duty_eff;

  assign w_pe   = ena && (cnt == DUTY_MAX);
  assign w_up   = duty_up(r_duty);
  assign w_down = duty_down(r_duty);

`ifdef LED_FADER_GAMMA_EN
  logic [2*WIDTH-1:0] w_sq;
  assign w_sq       = {{WIDTH{1'b0}}, r_duty} * {{WIDTH{1'b0}}, r_duty};
  assign w_duty_eff = w_sq[2*WIDTH-1:WIDTH];
`else
  assign w_duty_eff = r_duty;
`endif

  // PWM compare and boundary pulse run every clock, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= 1'b0;
      r_pe  <= 1'b0;
    end else begin
      r_pwm <= (cnt < w_duty_eff);
      r_pe  <= w_pe;
    end
  end

  // Duty only moves on period boundaries so a period never sees two compare values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_stop_pend <= 1'b0;
      r_duty      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_duty      <= '0;
          r_stop_pend <= 1'b0;
          if (start && !stop) r_state <= S_RAMP_UP;
        end
        S_RAMP_UP: begin
          if (stop) begin
            r_stop_pend <= 1'b1;
            r_state     <= S_RAMP_DOWN;
          end else if (w_pe) begin
            r_duty <= w_up;
            if (w_up == DUTY_MAX) begin
              r_state <= S_HOLD_HIGH;
              r_hold  <= '0;
            end
          end
        end
        S_HOLD_HIGH: begin
          if (stop) begin
            r_stop_pend <= 1'b1;
            r_state     <= S_RAMP_DOWN;
          end else if (w_pe) begin
            if (r_hold == HOLD_LAST) begin
              r_state <= S_RAMP_DOWN;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        S_RAMP_DOWN: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_pe) begin
            r_duty <= w_down;
            if (w_down == '0) begin
              if (r_stop_pend || stop) begin
                r_state     <= S_IDLE;
                r_stop_pend <= 1'b0;
              end else begin
                r_state <= S_HOLD_LOW;
                r_hold  <= '0;
              end
            end
          end
        end
        S_HOLD_LOW: begin
          // Duty is already 0 here, so a stop completes on the next boundary.
          if (stop) begin
            r_stop_pend <= 1'b1;
            r_state     <= S_RAMP_DOWN;
          end else if (w_pe) begin
            if (r_hold == HOLD_LAST) begin
              r_state <= S_RAMP_UP;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pwm        = r_pwm;
  assign duty       = r_duty;
  assign busy       = r_busy;
  assign period_end = r_pe;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with WIDTH=8, STEP=64, HOLD_PERIODS=2 and a bench-driven counter.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic       pwm;
  logic [7:0] duty;
  logic       busy;
  logic       period_end;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .WIDTH(8), .STEP(64), .HOLD_PERIODS(2), .HOLD_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .cnt(cnt), .start(start), .stop(stop),
    .pwm(pwm), .duty(duty), .busy(busy), .period_end(period_end)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_of(input int d);
`ifdef LED_FADER_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ena) cnt = cnt + 8'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pe(input string tag, input int exp_duty);
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (!period_end && i < 600);
    check({tag, "_pe"}, 32'(period_end), 32'd1);
    check(tag, 32'(duty), 32'(exp_duty));
  endtask

  task automatic count_pwm(input int n, input int dlin, output int highs, output int errs);
    int c;
    highs = 0;
    errs  = 0;
    for (int i = 0; i < n; i++) begin
      c = int'(cnt);
      tick();
      if (pwm !== (c < eff_of(dlin))) errs++;
      if (pwm === 1'b1) highs++;
    end
  endtask

  initial begin
    int highs, errs, pe_seen;

    // Reset state
    #2 rst = 1'b1;
    ticks(2);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pe", 32'(period_end), 32'd0);
    rst = 1'b0;
    ena = 1'b1;
    ticks(300);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_duty", 32'(duty), 32'd0);

    // Start and ramp up
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    check("start_busy", 32'(busy), 32'd1);
    wait_pe("up64", 64);
    wait_pe("up128", 128);

    // PWM shape at duty 128
    count_pwm(256, 128, highs, errs);
    check("pwm128_highs", 32'(highs), 32'(eff_of(128)));
    check("pwm128_errs", 32'(errs), 32'd0);
    check("up192_pe", 32'(period_end), 32'd1);
    check("up192", 32'(duty), 32'd192);
    wait_pe("up255", 255);

    // Hold high, ramp down, hold low, ramp up again
    wait_pe("hh1", 255);
    wait_pe("hh2", 255);
    wait_pe("dn191", 191);
    wait_pe("dn127", 127);
    wait_pe("dn63", 63);
    wait_pe("dn0", 0);
    wait_pe("hl1", 0);
    wait_pe("hl2", 0);
    wait_pe("again64", 64);
    check("cont_busy", 32'(busy), 32'd1);

    // ena low freezes everything except the PWM compare
    ticks(50);
    ena = 1'b0;
    pe_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (period_end === 1'b1) pe_seen++;
    end
    check("frz_pe", 32'(pe_seen), 32'd0);
    check("frz_duty", 32'(duty), 32'd64);
    check("frz_pwm", 32'(pwm), 32'(int'(cnt) < eff_of(64)));
    ena = 1'b1;
    wait_pe("resume128", 128);
    wait_pe("resume192", 192);
    wait_pe("resume255", 255);

    // Stop during hold high
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_pe("stop191", 191);
    wait_pe("stop127", 127);
    wait_pe("stop63", 63);
    wait_pe("stop0", 0);
    ticks(2);
    check("stop_busy", 32'(busy), 32'd0);
    count_pwm(256, 0, highs, errs);
    check("stop_pwm_highs", 32'(highs), 32'd0);
    check("stop_pwm_errs", 32'(errs), 32'd0);

    // start and stop together while idle
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    ticks(300);
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_duty", 32'(duty), 32'd0);

    // Asynchronous reset mid-ramp
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pe("r2_64", 64);
    wait_pe("r2_128", 128);
    ticks(10);
    check("pre_rst_pwm", 32'(pwm), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm", 32'(pwm), 32'd0);
    check("arst_duty", 32'(duty), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pe", 32'(period_end), 32'd0);
    tick();
    rst = 1'b0;
    ticks(300);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_duty", 32'(duty), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
